// File: rtl/psd_cdiv_sequencer.sv
// Initiator-side sequencer for the complex divider: runs two divisions (real, then imaginary)
// on the shared 32/16 sequential divider and returns both quotients/remainders on valid/ready.
module psd_cdiv_sequencer #(
  parameter int unsigned DW      = 32,
  parameter int unsigned VW      = 16,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] num_re,
  input  logic [DW-1:0] num_im,
  input  logic [VW-1:0] den,
  output logic          div_run,
  output logic [DW-1:0] div_dividend,
  output logic [VW-1:0] div_divisor,
  input  logic          div_busy,
  input  logic          div_stop,
  input  logic [DW-1:0] div_quotient,
  input  logic [VW-1:0] div_rest,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q_re,
  output logic [DW-1:0] q_im,
  output logic [VW-1:0] r_re,
  output logic [VW-1:0] r_im,
  output logic          err_zero,
  output logic          err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StRunRe, StWaitRe, StCapRe, StRunIm, StWaitIm, StCapIm, StOut
  } state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] num_im_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= StIdle;
      cnt          <= '0;
      num_im_q     <= '0;
      in_ready     <= 1'b1;
      div_run      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_valid    <= 1'b0;
      q_re         <= '0;
      q_im         <= '0;
      r_re         <= '0;
      r_im         <= '0;
      err_zero     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      div_run <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            in_ready    <= 1'b0;
            num_im_q    <= num_im;
            q_re        <= '0;
            q_im        <= '0;
            r_re        <= '0;
            r_im        <= '0;
            err_timeout <= 1'b0;
            if (den == '0) begin
              err_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= StOut;
            end else begin
              err_zero     <= 1'b0;
              div_dividend <= num_re;
              div_divisor  <= den;
              div_run      <= 1'b1;
              state        <= StRunRe;
            end
          end
        end
        StRunRe: state <= StWaitRe;
        StRunIm: state <= StWaitIm;
        StWaitRe, StWaitIm: begin
          if (div_stop) begin
            if (state == StWaitRe) state <= StCapRe;
            else                   state <= StCapIm;
          end else if (cnt == CntLast) begin
            // Abort: discard any real-part result already captured.
            cnt         <= '0;
            q_re        <= '0;
            q_im        <= '0;
            r_re        <= '0;
            r_im        <= '0;
            err_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= StOut;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StCapRe: begin
          q_re <= div_quotient;
          r_re <= div_rest;
          cnt  <= '0;
          // Never pulse run into a divider that has not yet released busy.
          if (!div_busy) begin
            div_dividend <= num_im_q;
            div_run      <= 1'b1;
            state        <= StRunIm;
          end
        end
        StCapIm: begin
          q_im      <= div_quotient;
          r_im      <= div_rest;
          cnt       <= '0;
          out_valid <= 1'b1;
          state     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_psd_cdiv_sequencer.sv
// Directed bench for psd_cdiv_sequencer with a behavioural 33-cycle sequential divider model.
module tb_psd_cdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] num_re = '0;
  logic [31:0] num_im = '0;
  logic [15:0] den = '0;
  logic        div_run;
  logic [31:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_busy;
  logic        div_stop;
  logic [31:0] div_quotient;
  logic [15:0] div_rest;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q_re, q_im;
  logic [15:0] r_re, r_im;
  logic        err_zero, err_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int run_busy_viol = 0;
  logic nostop = 1'b0;

  psd_cdiv_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .num_re(num_re), .num_im(num_im), .den(den), .div_run(div_run),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_busy(div_busy),
    .div_stop(div_stop), .div_quotient(div_quotient), .div_rest(div_rest),
    .out_valid(out_valid), .out_ready(out_ready), .q_re(q_re), .q_im(q_im),
    .r_re(r_re), .r_im(r_im), .err_zero(err_zero), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  // Divider model: stop 33 cycles after run, results loaded at the end of the stop cycle.
  logic       m_busy;
  logic [5:0] m_cnt;
  logic [31:0] m_a;
  logic [15:0] m_b;

  function automatic logic [31:0] mq(input logic [31:0] a, input logic [15:0] b);
    longint sa;
    sa = longint'($signed(a));
    return 32'(sa / longint'(b));
  endfunction

  function automatic logic [15:0] mr(input logic [31:0] a, input logic [15:0] b);
    longint sa;
    sa = longint'($signed(a));
    return 16'(sa % longint'(b));
  endfunction

  assign div_busy = m_busy;
  assign div_stop = m_busy && (m_cnt == 6'd33) && !nostop;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      m_busy       <= 1'b0;
      m_cnt        <= '0;
      m_a          <= '0;
      m_b          <= '0;
      div_quotient <= '0;
      div_rest     <= '0;
    end else begin
      if (div_run && div_busy) run_busy_viol <= run_busy_viol + 1;
      if (div_run) begin
        m_busy <= 1'b1;
        m_cnt  <= 6'd1;
        m_a    <= div_dividend;
        m_b    <= div_divisor;
      end else if (div_stop) begin
        m_busy       <= 1'b0;
        div_quotient <= mq(m_a, m_b);
        div_rest     <= mr(m_a, m_b);
      end else if (m_busy) begin
        m_cnt <= m_cnt + 6'd1;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Offers a job; returns #1 after the handshake edge (cycle 1 relative to the handshake).
  task automatic start_job(input logic [31:0] re, input logic [31:0] im, input logic [15:0] d);
    int n = 0;
    num_re = re; num_im = im; den = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1; n++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic watch(input int limit, output int t_out, output int nrun, output int rt0,
                       output int rt1, output logic [31:0] dd0, output logic [31:0] dd1,
                       output logic [15:0] dv0);
    t_out = -1; nrun = 0; rt0 = -1; rt1 = -1; dd0 = '0; dd1 = '0; dv0 = '0;
    for (int t = 1; t <= limit; t++) begin
      if (div_run) begin
        if (nrun == 0) begin rt0 = t; dd0 = div_dividend; dv0 = div_divisor; end
        else if (nrun == 1) begin rt1 = t; dd1 = div_dividend; end
        nrun++;
      end
      if (out_valid) begin t_out = t; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (div_run !== 1'b0) begin failures++; $display("FAIL rst_div_run: got %b want 0", div_run); end
    checks++; if ({q_re, q_im, r_re, r_im, err_zero, err_timeout} !== '0) begin failures++; $display("FAIL rst_results: got %h want 0", {q_re, q_im, r_re, r_im, err_zero, err_timeout}); end
    checks++; if ({div_dividend, div_divisor} !== '0) begin failures++; $display("FAIL rst_div_operands: got %h want 0", {div_dividend, div_divisor}); end
  endtask

  task automatic test_basic();
    int t_out, nrun, rt0, rt1;
    logic [31:0] dd0, dd1;
    logic [15:0] dv0;
    start_job(32'd100, 32'd45, 16'd7);
    watch(200, t_out, nrun, rt0, rt1, dd0, dd1, dv0);
    checks++; if (nrun != 2) begin failures++; $display("FAIL basic_run_count: got %0d want 2", nrun); end
    checks++; if (rt0 != 1 || rt1 != 36) begin failures++; $display("FAIL basic_run_cycles: got %0d,%0d want 1,36", rt0, rt1); end
    checks++; if (dd0 !== 32'd100 || dd1 !== 32'd45 || dv0 !== 16'd7) begin failures++; $display("FAIL basic_operands: got %0d,%0d,%0d want 100,45,7", dd0, dd1, dv0); end
    checks++; if (t_out != 71) begin failures++; $display("FAIL basic_latency: got %0d want 71", t_out); end
    checks++; if (q_re !== 32'd14 || r_re !== 16'd2) begin failures++; $display("FAIL basic_re: got q=%0d r=%0d want 14,2", q_re, r_re); end
    checks++; if (q_im !== 32'd6 || r_im !== 16'd3) begin failures++; $display("FAIL basic_im: got q=%0d r=%0d want 6,3", q_im, r_im); end
    checks++; if (err_zero !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL basic_err: got %b%b want 00", err_zero, err_timeout); end
    release_out();
  endtask

  task automatic test_zero_den();
    int t_out, nrun, rt0, rt1;
    logic [31:0] dd0, dd1;
    logic [15:0] dv0;
    start_job(32'd5, 32'd9, 16'd0);
    watch(50, t_out, nrun, rt0, rt1, dd0, dd1, dv0);
    checks++; if (t_out != 1) begin failures++; $display("FAIL zero_latency: got %0d want 1", t_out); end
    checks++; if (nrun != 0) begin failures++; $display("FAIL zero_no_run: got %0d runs want 0", nrun); end
    checks++; if (err_zero !== 1'b1 || err_timeout !== 1'b0) begin failures++; $display("FAIL zero_err: got %b%b want 10", err_zero, err_timeout); end
    checks++; if ({q_re, q_im, r_re, r_im} !== '0) begin failures++; $display("FAIL zero_results: got %h want 0", {q_re, q_im, r_re, r_im}); end
    release_out();
  endtask

  task automatic test_timeout();
    int t_out, nrun, rt0, rt1, extra;
    logic [31:0] dd0, dd1;
    logic [15:0] dv0;
    nostop = 1'b1;
    start_job(32'd77, 32'd33, 16'd3);
    watch(200, t_out, nrun, rt0, rt1, dd0, dd1, dv0);
    checks++; if (t_out != 42) begin failures++; $display("FAIL tmo_latency: got %0d want 42", t_out); end
    checks++; if (err_timeout !== 1'b1 || err_zero !== 1'b0) begin failures++; $display("FAIL tmo_err: got %b%b want 01", err_zero, err_timeout); end
    checks++; if ({q_re, q_im, r_re, r_im} !== '0) begin failures++; $display("FAIL tmo_results: got %h want 0", {q_re, q_im, r_re, r_im}); end
    extra = 0;
    repeat (5) begin @(posedge clock); #1; if (div_run) extra++; end
    checks++; if (nrun != 1 || extra != 0) begin failures++; $display("FAIL tmo_single_run: got %0d+%0d runs want 1", nrun, extra); end
    nostop = 1'b0;
    do_reset();
  endtask

  task automatic test_stall();
    int t_out, nrun, rt0, rt1, bad;
    logic [31:0] dd0, dd1;
    logic [15:0] dv0;
    start_job(32'd100, 32'd45, 16'd7);
    watch(200, t_out, nrun, rt0, rt1, dd0, dd1, dv0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || in_ready || q_re !== 32'd14 || r_re !== 16'd2 || q_im !== 32'd6 ||
          r_im !== 16'd3) bad++;
      @(posedge clock); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_stable: got %0d bad cycles want 0", bad); end
    release_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL stall_release: got valid=%b ready=%b want 0,1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int t_out, nrun, rt0, rt1;
    logic [31:0] dd0, dd1;
    logic [15:0] dv0;
    start_job(32'd100, 32'd45, 16'd7);
    repeat (19) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_run !== 1'b0) begin failures++; $display("FAIL mid_reset_idle: got ready=%b valid=%b run=%b want 1,0,0", in_ready, out_valid, div_run); end
    checks++; if ({q_re, r_re} !== '0) begin failures++; $display("FAIL mid_reset_clear: got %h want 0", {q_re, r_re}); end
    start_job(32'h7FFF_FFFF, 32'h0001_2345, 16'hFFFF);
    watch(200, t_out, nrun, rt0, rt1, dd0, dd1, dv0);
    checks++; if (t_out != 71) begin failures++; $display("FAIL mid_latency: got %0d want 71", t_out); end
    checks++; if (q_re !== 32'h0000_8000 || r_re !== 16'h7FFF) begin failures++; $display("FAIL mid_re: got q=%h r=%h want 00008000,7fff", q_re, r_re); end
    checks++; if (q_im !== 32'd1 || r_im !== 16'h2346) begin failures++; $display("FAIL mid_im: got q=%h r=%h want 00000001,2346", q_im, r_im); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int hs0, hs1, n;
    hs0 = -1; hs1 = -1; n = 0;
    num_re = 32'd100; num_im = 32'd45; den = 16'd7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (hs1 < 0 && n < 400) begin
      @(negedge clock);
      if (in_valid && in_ready) begin
        if (hs0 < 0) hs0 = cyc; else hs1 = cyc;
      end
      n++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++; if (hs1 - hs0 != 72) begin failures++; $display("FAIL b2b_spacing: got %0d want 72", hs1 - hs0); end
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clock); #1; n++; end
    checks++; if (!out_valid || q_re !== 32'd14 || q_im !== 32'd6) begin failures++; $display("FAIL b2b_second_result: got v=%b q=%0d,%0d want 1,14,6", out_valid, q_re, q_im); end
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++; if (run_busy_viol != 0) begin failures++; $display("FAIL run_while_busy: got %0d want 0", run_busy_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_den();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
